// File: rtl/pipe_stage_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, one-entry skid buffer and flush.
// Optional stall-cycle counter enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_skid_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] INIT_VALUE  = '0,
  parameter bit               OUTPUT_GATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_skid_full
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]      o_stall_cycles
`endif
);

  // state    | meaning
  // ST_EMPTY | no valid data held
  // ST_FULL  | main entry valid, skid empty
  // ST_SKID  | main and skid entries both valid
  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_in_fire;
  logic             w_out_fire;

  assign o_valid     = (r_state != ST_EMPTY);
  assign o_ready     = (r_state != ST_SKID);
  assign o_skid_full = (r_state == ST_SKID);

  assign w_in_fire  = i_valid & o_ready;
  assign w_out_fire = o_valid & i_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_main  <= INIT_VALUE;
      r_skid  <= INIT_VALUE;
    end else if (i_flush) begin
      // Flush only invalidates; the data registers keep their contents.
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            r_main  <= i_data;
            r_state <= ST_FULL;
          end
        end
        ST_FULL: begin
          case ({w_in_fire, w_out_fire})
            2'b11: r_main <= i_data;
            2'b10: begin
              r_skid  <= i_data;
              r_state <= ST_SKID;
            end
            2'b01: r_state <= ST_EMPTY;
            default: r_state <= ST_FULL;
          endcase
        end
        ST_SKID: begin
          if (w_out_fire) begin
            r_main  <= r_skid;
            r_state <= ST_FULL;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  generate
    if (OUTPUT_GATE) begin : g_gate
      assign o_data = {WIDTH{o_valid}} & r_main;
    end else begin : g_nogate
      assign o_data = r_main;
    end
  endgenerate

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] r_stall_cnt;

  // Counts through flush cycles; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (o_valid && !i_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: directed scenarios plus random traffic against a queue model.
// Two instances share stimulus: one ungated, one with OUTPUT_GATE=1.
module tb_pipe_stage_skid_reg;
  localparam int          W    = 32;
  localparam logic [31:0] INIT = 32'h5A;

  logic          clk = 1'b0;
  logic          reset, i_valid, i_flush, i_ready;
  logic [W-1:0]  i_data;
  logic          o_ready0, o_valid0, o_skid0, o_ready1, o_valid1, o_skid1;
  logic [W-1:0]  o_data0, o_data1;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0]   o_stall0, o_stall1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(.WIDTH(W), .INIT_VALUE(INIT), .OUTPUT_GATE(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready0), .i_data(i_data),
    .i_flush(i_flush), .o_valid(o_valid0), .i_ready(i_ready), .o_data(o_data0),
    .o_skid_full(o_skid0)
`ifdef PIPE_STAGE_STATS_EN
    , .o_stall_cycles(o_stall0)
`endif
  );

  pipe_stage_skid_reg #(.WIDTH(W), .INIT_VALUE(INIT), .OUTPUT_GATE(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready1), .i_data(i_data),
    .i_flush(i_flush), .o_valid(o_valid1), .i_ready(i_ready), .o_data(o_data1),
    .o_skid_full(o_skid1)
`ifdef PIPE_STAGE_STATS_EN
    , .o_stall_cycles(o_stall1)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stage is a FIFO of depth two; the held main value
  // persists across drain and flush.
  logic [31:0] q[$];
  logic [31:0] m_main = INIT;
  logic [31:0] m_stall = 0;

  always @(posedge clk) begin : model
    bit f_in, f_out;
    if (reset) begin
      q.delete();
      m_main  = INIT;
      m_stall = 0;
    end else begin
      f_out = (q.size() > 0) && i_ready;
      f_in  = i_valid && (q.size() < 2);
      if ((q.size() > 0) && !i_ready && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 1;
      if (i_flush) begin
        q.delete();
      end else begin
        if (f_out) void'(q.pop_front());
        if (f_in) q.push_back(i_data);
        if (q.size() > 0) m_main = q[0];
      end
    end
  end

  always @(negedge clk) begin : compare
    logic mv;
    mv = (q.size() > 0);
    chk("valid0", {31'd0, o_valid0}, {31'd0, mv});
    chk("valid1", {31'd0, o_valid1}, {31'd0, mv});
    chk("ready0", {31'd0, o_ready0}, {31'd0, q.size() < 2});
    chk("ready1", {31'd0, o_ready1}, {31'd0, q.size() < 2});
    chk("skid0", {31'd0, o_skid0}, {31'd0, q.size() == 2});
    chk("skid1", {31'd0, o_skid1}, {31'd0, q.size() == 2});
    chk("data0", o_data0, m_main);
    chk("data1", o_data1, mv ? m_main : 32'd0);
`ifdef PIPE_STAGE_STATS_EN
    chk("stall0", o_stall0, m_stall);
    chk("stall1", o_stall1, m_stall);
`endif
  end

  task automatic step(input logic v, input logic [31:0] d, input logic r,
                      input logic f = 1'b0, input logic rs = 1'b0);
    i_valid = v; i_data = d; i_ready = r; i_flush = f; reset = rs;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; i_valid = 1'b0; i_data = '0; i_flush = 1'b0; i_ready = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    chk("rst_valid", {31'd0, o_valid0}, 32'd0);
    chk("rst_ready", {31'd0, o_ready0}, 32'd1);
    chk("rst_skid", {31'd0, o_skid0}, 32'd0);
    chk("rst_data0", o_data0, 32'h5A);
    chk("rst_data1", o_data1, 32'h0);

    // streaming
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, k, 1'b1);
      chk("strm_valid", {31'd0, o_valid0}, 32'd1);
      chk("strm_data", o_data0, k);
      chk("strm_ready", {31'd0, o_ready0}, 32'd1);
      chk("strm_skid", {31'd0, o_skid0}, 32'd0);
    end
    step(1'b0, 32'h0, 1'b1);
    chk("strm_drain_v", {31'd0, o_valid0}, 32'd0);
    chk("strm_drain_d1", o_data1, 32'h0);

    // backpressure into skid
    step(1'b1, 32'hA, 1'b0);
    chk("bp_data_a", o_data0, 32'hA);
    step(1'b1, 32'hB, 1'b0);
    chk("bp_skid", {31'd0, o_skid0}, 32'd1);
    chk("bp_ready", {31'd0, o_ready0}, 32'd0);
    chk("bp_data_a2", o_data0, 32'hA);
    step(1'b1, 32'hC, 1'b1);
    chk("bp_data_b", o_data0, 32'hB);
    chk("bp_ready_back", {31'd0, o_ready0}, 32'd1);
    step(1'b0, 32'h0, 1'b1);
    chk("bp_empty", {31'd0, o_valid0}, 32'd0);

    // flush while in skid, with a discarded input
    step(1'b1, 32'h11, 1'b0);
    step(1'b1, 32'h22, 1'b0);
    chk("fl_skid", {31'd0, o_skid0}, 32'd1);
    step(1'b1, 32'h33, 1'b0, 1'b1);
    chk("fl_valid", {31'd0, o_valid0}, 32'd0);
    chk("fl_ready", {31'd0, o_ready0}, 32'd1);
    chk("fl_hold", o_data0, 32'h11);
    step(1'b0, 32'h0, 1'b1);
    chk("fl_no33", {31'd0, o_valid0}, 32'd0);

    // reset outranks flush
    step(1'b1, 32'h77, 1'b0);
    chk("rp_full", o_data0, 32'h77);
    step(1'b1, 32'h99, 1'b0, 1'b1, 1'b1);
    chk("rp_valid", {31'd0, o_valid0}, 32'd0);
    chk("rp_data", o_data0, 32'h5A);
    chk("rp_ready", {31'd0, o_ready0}, 32'd1);

    // output gating
    step(1'b1, 32'hFFFF_FFFF, 1'b0);
    chk("gt_pass", o_data1, 32'hFFFF_FFFF);
    step(1'b0, 32'h0, 1'b0);
    chk("gt_hold", o_data1, 32'hFFFF_FFFF);
    step(1'b0, 32'h0, 1'b1);
    chk("gt_zero", o_data1, 32'h0);
    chk("gt_ungated", o_data0, 32'hFFFF_FFFF);

`ifdef PIPE_STAGE_STATS_EN
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h5, 1'b0);
    for (int k = 0; k < 7; k++) step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h6, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b0);
    chk("stats_ten", o_stall0, 32'd10);
`endif

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 65,
           $urandom_range(0, 99) < 4, $urandom_range(0, 199) < 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
